// File: rtl/xsram_if.sv
// Synchronous bridge from a W-bit request port to a narrow XW-bit asynchronous SRAM bus.
// Each access runs BEATS x (ADDR, STRB x (WAIT+1), HOLD); all pin outputs come from flops.
module xsram_if #(
   parameter int W    = 16,
   parameter int XW   = 8,
   parameter int AW   = 17,
   parameter int WAIT = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req,
   input  logic          we,
   input  logic          word,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic          busy,
   output logic          rdy,
   output logic [W-1:0]  rdata,
   output logic          ram_ce_n,
   output logic          ram_oe_n,
   output logic          ram_we_n,
   output logic [AW-1:0] xa,
   output logic [XW-1:0] xd_o,
   output logic          xd_oe,
   input  logic [XW-1:0] xd_i
);

   localparam int BEATS = W / XW;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STRB, S_HOLD} state_t;

   state_t          state_q, state_d;
   logic            we_q, we_d;
   logic            word_q, word_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [W-1:0]    wsh_q, wsh_d;
   logic [W-1:0]    rsh_q, rsh_d;
   logic [W-1:0]    rdata_q, rdata_d;
   logic [AW-1:0]   xa_q, xa_d;
   logic [XW-1:0]   xd_q, xd_d;
   logic            xd_oe_q, xd_oe_d;
   logic            ce_n_q, ce_n_d;
   logic            oe_n_q, oe_n_d;
   logic            we_n_q, we_n_d;

   logic            last_beat;
   logic            accept;
   logic            strb_done;
   logic [W-1:0]    src;
   logic [W-1:0]    rd_next;

   assign last_beat = !word_q || (beat_q == BW'(BEATS - 1));
   assign busy      = (state_q != S_IDLE) && !((state_q == S_HOLD) && last_beat);
   assign rdy       = (state_q == S_HOLD) && last_beat;
   assign accept    = req && !busy;
   assign strb_done = (state_q == S_STRB) && (cnt_q == 3'(WAIT));

   assign rdata     = rdata_q;
   assign xa        = xa_q;
   assign xd_o      = xd_q;
   assign xd_oe     = xd_oe_q;
   assign ram_ce_n  = ce_n_q;
   assign ram_oe_n  = oe_n_q;
   assign ram_we_n  = we_n_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (req) state_d = S_ADDR;
         S_ADDR: state_d = S_STRB;
         S_STRB: if (strb_done) state_d = S_HOLD;
         S_HOLD: begin
            if (!last_beat || req) state_d = S_ADDR;
            else                   state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pin values are computed for the state being entered so they are valid for the whole cycle.
   always_comb begin
      we_d    = we_q;
      word_d  = word_q;
      beat_d  = beat_q;
      cnt_d   = (state_q == S_STRB) ? cnt_q + 3'd1 : 3'd0;
      wsh_d   = wsh_q;
      rsh_d   = rsh_q;
      rdata_d = rdata_q;
      xa_d    = xa_q;
      xd_d    = xd_q;
      xd_oe_d = xd_oe_q;
      ce_n_d  = ce_n_q;
      oe_n_d  = 1'b1;
      we_n_d  = 1'b1;
      src     = wsh_q;
      rd_next = W'({rsh_q, xd_i});

      // A byte write is parked in the top slice so it leaves on beat 0 like a word's MSB.
      if (accept) begin
         we_d   = we;
         word_d = word;
         src    = word ? wdata : (wdata << (W - XW));
      end

      case (state_d)
         S_ADDR: begin
            ce_n_d = 1'b0;
            xd_d   = src[W-1 -: XW];
            wsh_d  = src << XW;
            if (accept) begin
               xa_d    = addr;
               beat_d  = '0;
               xd_oe_d = we;
            end else begin
               xa_d    = xa_q + 1'b1;
               beat_d  = beat_q + 1'b1;
               xd_oe_d = we_q;
            end
         end
         S_STRB: begin
            oe_n_d = we_q;
            we_n_d = !we_q;
         end
         S_IDLE: begin
            ce_n_d  = 1'b1;
            xd_oe_d = 1'b0;
         end
         default: ;
      endcase

      if (strb_done && !we_q) begin
         rsh_d = rd_next;
         if (last_beat) rdata_d = word_q ? rd_next : W'(xd_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         word_q  <= 1'b0;
         beat_q  <= '0;
         cnt_q   <= 3'd0;
         wsh_q   <= '0;
         rsh_q   <= '0;
         rdata_q <= '0;
         xa_q    <= '0;
         xd_q    <= '0;
         xd_oe_q <= 1'b0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
      end else begin
         we_q    <= we_d;
         word_q  <= word_d;
         beat_q  <= beat_d;
         cnt_q   <= cnt_d;
         wsh_q   <= wsh_d;
         rsh_q   <= rsh_d;
         rdata_q <= rdata_d;
         xa_q    <= xa_d;
         xd_q    <= xd_d;
         xd_oe_q <= xd_oe_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
      end
   end

endmodule

// File: tb/tb_xsram_if.sv
// Bench for xsram_if: two instances (WAIT=0 and WAIT=2) share one behavioural SRAM array.
// Expected data, latency and strobe windows come from a transaction-level model.
module tb_xsram_if;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req0, req1, we_i, word_i;
   logic [16:0] addr_i;
   logic [15:0] wdata_i;

   logic        busy0, rdy0, ce_n0, oe_n0, we_n0, xd_oe0;
   logic [15:0] rdata0;
   logic [16:0] xa0;
   logic [7:0]  xd_o0, xd_i0;
   logic        busy1, rdy1, ce_n1, oe_n1, we_n1, xd_oe1;
   logic [15:0] rdata1;
   logic [16:0] xa1;
   logic [7:0]  xd_o1, xd_i1;

   logic [7:0]  mem [0:131071];
   logic        sel;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] rd_model [2];

   xsram_if #(.W(16), .XW(8), .AW(17), .WAIT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .req(req0), .we(we_i), .word(word_i), .addr(addr_i),
      .wdata(wdata_i), .busy(busy0), .rdy(rdy0), .rdata(rdata0), .ram_ce_n(ce_n0),
      .ram_oe_n(oe_n0), .ram_we_n(we_n0), .xa(xa0), .xd_o(xd_o0), .xd_oe(xd_oe0), .xd_i(xd_i0));

   xsram_if #(.W(16), .XW(8), .AW(17), .WAIT(2)) u1 (
      .clk(clk), .rst_n(rst_n), .req(req1), .we(we_i), .word(word_i), .addr(addr_i),
      .wdata(wdata_i), .busy(busy1), .rdy(rdy1), .rdata(rdata1), .ram_ce_n(ce_n1),
      .ram_oe_n(oe_n1), .ram_we_n(we_n1), .xa(xa1), .xd_o(xd_o1), .xd_oe(xd_oe1), .xd_i(xd_i1));

   // Asynchronous SRAM: reads follow the address, writes land while we_n is low.
   assign xd_i0 = mem[xa0];
   assign xd_i1 = mem[xa1];
   always @(posedge clk) begin
      if (!ce_n0 && !we_n0) mem[xa0] <= xd_o0;
      if (!ce_n1 && !we_n1) mem[xa1] <= xd_o1;
   end

   logic        busy_m, rdy_m, oe_m, we_m;
   logic [15:0] rdata_m;
   assign busy_m  = sel ? busy1  : busy0;
   assign rdy_m   = sel ? rdy1   : rdy0;
   assign oe_m    = sel ? oe_n1  : oe_n0;
   assign we_m    = sel ? we_n1  : we_n0;
   assign rdata_m = sel ? rdata1 : rdata0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pin protocol: strobes exclusive, address/data frozen while and right after we_n is low.
   logic [16:0] pxa0, pxa1;
   logic [7:0]  pxd0, pxd1;
   logic        pw0, pw1;
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pw0 = 1'b0;
         pw1 = 1'b0;
      end else begin
         if (!oe_n0 || !we_n0) chk("strobe_excl0", {31'd0, oe_n0 | we_n0}, 32'd1);
         if (!oe_n1 || !we_n1) chk("strobe_excl1", {31'd0, oe_n1 | we_n1}, 32'd1);
         if (!we_n0 || pw0) begin
            chk("xa_stable0", {15'd0, xa0}, {15'd0, pxa0});
            chk("xd_stable0", {24'd0, xd_o0}, {24'd0, pxd0});
         end
         if (!we_n1 || pw1) begin
            chk("xa_stable1", {15'd0, xa1}, {15'd0, pxa1});
            chk("xd_stable1", {24'd0, xd_o1}, {24'd0, pxd1});
         end
         pxa0 = xa0; pxd0 = xd_o0; pw0 = !we_n0;
         pxa1 = xa1; pxd1 = xd_o1; pw1 = !we_n1;
      end
   end

   function automatic logic [31:0] strobe_mask(input int beats, input int wt);
      logic [31:0] m;
      m = '0;
      for (int k = 0; k < beats; k++)
         for (int j = 0; j <= wt; j++) m[k*(wt+3)+2+j] = 1'b1;
      return m;
   endfunction

   task automatic start(input bit s, input bit w, input bit wd, input logic [16:0] a,
                        input logic [15:0] d);
      @(negedge clk);
      sel = s;
      chk("idle_busy", {31'd0, busy_m}, 32'd0);
      we_i = w; word_i = wd; addr_i = a; wdata_i = d;
      if (s) req1 = 1'b1; else req0 = 1'b1;
      @(posedge clk);
      #1;
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output logic [31:0] om, output logic [31:0] wm,
                            output int bc, output logic [15:0] rd);
      cyc = 0; om = '0; wm = '0; bc = 0; rd = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (!oe_m && c < 32) om[c] = 1'b1;
         if (!we_m && c < 32) wm[c] = 1'b1;
         if (busy_m) bc++;
         if (rdy_m) begin
            cyc = c;
            rd  = rdata_m;
            break;
         end
      end
      if (cyc == 0) chk("timeout", {31'd0, rdy_m}, 32'd1);
   endtask

   task automatic txn(input bit s, input bit w, input bit wd, input logic [16:0] a,
                      input logic [15:0] d);
      int          beats, wt, cyc, bc;
      logic [31:0] om, wm, em;
      logic [15:0] rd, exp_rd;
      logic [16:0] a1;
      beats  = wd ? 2 : 1;
      wt     = s ? 2 : 0;
      a1     = a + 17'd1;
      exp_rd = wd ? {mem[a], mem[a1]} : {8'h00, mem[a]};
      start(s, w, wd, a, d);
      wait_done(cyc, om, wm, bc, rd);
      chk("latency", cyc, beats * (wt + 3));
      chk("busy_cycles", bc, cyc - 1);
      em = strobe_mask(beats, wt);
      if (w) begin
         chk("we_window", wm, em);
         chk("oe_idle", om, 32'd0);
         if (wd) begin
            chk("mem_b0", {24'd0, mem[a]}, {24'd0, d[15:8]});
            chk("mem_b1", {24'd0, mem[a1]}, {24'd0, d[7:0]});
         end else begin
            chk("mem_byte", {24'd0, mem[a]}, {24'd0, d[7:0]});
         end
      end else begin
         chk("oe_window", om, em);
         chk("we_idle", wm, 32'd0);
         rd_model[s] = exp_rd;
      end
      chk("rdata", {16'd0, rd}, {16'd0, rd_model[s]});
   endtask

   initial begin
      int          r1, r2, ce_hi, rdy_cnt;
      logic [15:0] d1, d2;
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; sel = 1'b0;
      we_i = 1'b0; word_i = 1'b0; addr_i = '0; wdata_i = '0;
      rd_model[0] = '0; rd_model[1] = '0;
      for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_rdy", {31'd0, rdy0}, 32'd0);
      chk("rst_rdata", {16'd0, rdata0}, 32'd0);
      chk("rst_xa", {15'd0, xa0}, 32'd0);
      chk("rst_xd_o", {24'd0, xd_o0}, 32'd0);
      chk("rst_strobes", {28'd0, xd_oe0, ce_n0, oe_n0, we_n0}, 32'h7);
      chk("rst_strobes1", {28'd0, xd_oe1, ce_n1, oe_n1, we_n1}, 32'h7);
      rst_n = 1'b1;

      mem[17'h000FE] = 8'h12; mem[17'h000FF] = 8'h34;
      txn(0, 0, 1, 17'h000FE, 16'h0);
      chk("word_read", {16'd0, rdata0}, 32'h1234);

      txn(1, 1, 1, 17'h00010, 16'hABCD);
      chk("wr_sram10", {24'd0, mem[17'h10]}, 32'hAB);
      chk("wr_keeps_rdata", {16'd0, rdata1}, {16'd0, rd_model[1]});

      mem[17'h1FFFF] = 8'hC3; mem[17'h00000] = 8'h7E;
      txn(0, 0, 1, 17'h1FFFF, 16'h0);
      chk("wrap_read", {16'd0, rdata0}, 32'hC37E);

      mem[17'h20] = 8'hFF; mem[17'h21] = 8'hFF; mem[17'h30] = 8'h5A;
      txn(0, 0, 1, 17'h00020, 16'h0);
      txn(0, 0, 0, 17'h00030, 16'h0);
      chk("byte_read", {16'd0, rdata0}, 32'h005A);

      txn(1, 1, 0, 17'h00031, 16'h12E7);
      txn(1, 0, 1, 17'h00030, 16'h0);
      chk("byte_write", {16'd0, rdata1}, 32'h5AE7);

      // Two word reads with req held: no IDLE between them.
      mem[17'h40] = 8'h11; mem[17'h41] = 8'h22; mem[17'h42] = 8'h33; mem[17'h43] = 8'h44;
      @(negedge clk);
      sel = 1'b0; we_i = 1'b0; word_i = 1'b1; addr_i = 17'h40; req0 = 1'b1;
      @(posedge clk);
      #1;
      r1 = 0; r2 = 0; ce_hi = 0; d1 = '0; d2 = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (ce_n0) ce_hi++;
         if (r1 != 0 && c == r1 + 1) req0 = 1'b0;
         if (rdy0) begin
            if (r1 == 0) begin
               r1 = c; d1 = rdata0; addr_i = 17'h42;
            end else begin
               r2 = c; d2 = rdata0;
               break;
            end
         end
      end
      req0 = 1'b0;
      chk("b2b_first", r1, 6);
      chk("b2b_gap", r2 - r1, 6);
      chk("b2b_d1", {16'd0, d1}, 32'h1122);
      chk("b2b_d2", {16'd0, d2}, 32'h3344);
      chk("b2b_no_idle", ce_hi, 0);
      rd_model[0] = 16'h3344;

      // Reset pulse in the middle of a write strobe.
      start(1, 1, 1, 17'h00050, 16'h1357);
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_pins", {28'd0, xd_oe1, ce_n1, oe_n1, we_n1}, 32'h7);
      chk("mid_rst_busy", {30'd0, busy1, rdy1}, 32'd0);
      chk("mid_rst_rdata", {16'd0, rdata0}, 32'd0);
      #1 rst_n = 1'b1;
      rd_model[0] = '0; rd_model[1] = '0;
      rdy_cnt = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (rdy1 || busy1) rdy_cnt++;
      end
      chk("mid_rst_quiet", rdy_cnt, 0);
      txn(1, 1, 1, 17'h00050, 16'h2468);
      txn(1, 0, 1, 17'h00050, 16'h0);
      chk("after_rst", {16'd0, rdata1}, 32'h2468);

      for (int i = 0; i < 12; i++) begin
         bit          s, w, wd;
         logic [16:0] a;
         s  = 1'($urandom_range(0, 1));
         w  = 1'($urandom_range(0, 1));
         wd = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 3) == 0) ? 17'h1FFFF - 17'($urandom_range(0, 1))
                                          : 17'($urandom_range(0, 15));
         txn(s, w, wd, a, 16'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/xsram_if.md
# xsram_if

Parametrised external asynchronous SRAM interface that bridges one on-chip request port, up to W bits wide, to a narrow XW-bit SRAM data bus. A word access is split into W/XW sequential byte beats, with configurable wait states and explicit address setup and hold phases. The block sits between the processor/DMA memory controller and the board SRAM pins. It replaces the fixed 16-over-8 half-cycle capture scheme with a fully synchronous, single-edge design.

## Interface
- W, 16: on-chip data width; must be a multiple of XW.
- XW, 8: external SRAM data width.
- AW, 17: external address width.
- WAIT, 0: extra strobe cycles per beat, range 0..7.

- clk  in  1  global clock; all state changes on the rising edge.
- rst_n  in  1  global reset, asynchronous, active-low.
- req  in  1  access request; sampled only while busy=0.
- we  in  1  1=write, 0=read; sampled with req.
- word  in  1  1=full W-bit access, 0=single XW-bit access; sampled with req.
- addr  in  AW  byte address of beat 0; sampled with req.
- wdata  in  W  write data; sampled with req.
- busy  out  1  transaction in progress, request not accepted.
- rdy  out  1  one-cycle completion pulse.
- rdata  out  W  read data; valid with rdy and held until the next read completes.
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active-low.
- xa  out  AW  SRAM address.
- xd_o  out  XW  SRAM write data.
- xd_oe  out  1  drive enable for xd_o; the top level builds the tristate.
- xd_i  in  XW  SRAM read data.

## Operation
- States: IDLE, ADDR, STRB, HOLD.
- A request sampled with busy=0 latches we, word, addr and wdata, then enters ADDR.
- BEATS = W/XW when word=1; BEATS = 1 when word=0.
- Beat k address: xa = (addr + k) mod 2^AW. The address wraps; no error is raised.
- Byte order is big-endian. Beat 0 carries the most-significant XW bits: wdata[W-1-k·XW -: XW].
- Byte access (word=0):
  - A write uses wdata[XW-1:0].
  - A read returns the byte in rdata[XW-1:0]; the upper bits read as zero.
- ADDR (1 cycle):
  - xa is valid and ram_ce_n=0.
  - For writes, xd_o is valid and xd_oe=1.
- STRB (WAIT+1 cycles):
  - ram_oe_n=0 for reads; ram_we_n=0 for writes.
  - An internal counter runs 0..WAIT.
  - For reads, xd_i is captured into the beat's slice of the read shift register on the clock edge that leaves STRB.
- HOLD (1 cycle):
  - Strobes are deasserted; xa, ram_ce_n and xd_o/xd_oe stay unchanged.
  - If this is not the last beat, go to ADDR with k+1.
- Final HOLD:
  - rdy=1 and busy=0. rdata is updated on the edge entering this cycle.
  - If req=1, the next transaction is accepted and goes directly to ADDR. Otherwise go to IDLE.
- IDLE: ram_ce_n=1, xd_oe=0, busy=0.
- ram_oe_n and ram_we_n are never low in the same cycle.
- ram_we_n is never low while xa or xd_o changes.
- Writes leave rdata unchanged.

## Timing
- Reset values: busy=0, rdy=0, rdata=0, xa=0, xd_o=0, xd_oe=0, ram_ce_n=1, ram_oe_n=1, ram_we_n=1; state=IDLE.
- Reset mid-transaction: all outputs return to their reset values asynchronously and the transaction is dropped. No completion pulse follows.
- Cycles per beat = WAIT+3.
- Transaction latency = BEATS·(WAIT+3) cycles from the accepting edge to the end of the rdy cycle.
  - Example, W=16, WAIT=0: a word read asserts rdy in the 6th cycle after acceptance.
- Back-to-back throughput: one transaction per BEATS·(WAIT+3) cycles. IDLE is not inserted when req is held high.
- busy rises in the cycle after acceptance and stays high through the last beat's STRB.
- Outputs are registered. Only busy and rdy are decoded from state registers.

## Test plan
- Word read, W=16, WAIT=0, addr=0x000FE, SRAM[0xFE]=0x12, SRAM[0xFF]=0x34 -> rdata=0x1234; rdy high exactly in cycle 6; ram_oe_n low in cycles 2 and 5 only.
- Word write, WAIT=2, addr=0x00010, wdata=0xABCD -> SRAM[0x10]=0xAB, SRAM[0x11]=0xCD; ram_we_n low for exactly 3 cycles per beat; xa and xd_o stable from ADDR through HOLD; rdy in cycle 10.
- Address wrap, AW=17, word read at addr=0x1FFFF -> beats use xa=0x1FFFF, then 0x00000; rdata = {SRAM[0x1FFFF], SRAM[0x00000]}.
- Byte read of 0x5A after a previous rdata of 0xFFFF -> rdata=0x005A; exactly one beat; rdy in cycle 3.
- req held high across two word reads -> the second ADDR immediately follows the first final HOLD; two rdy pulses 6 cycles apart; no IDLE cycle between them.
- rst_n pulsed low during the STRB of a write -> ram_we_n, xd_oe, ram_ce_n and busy return to their reset values without waiting for a clock; no rdy pulse; the next request completes normally.
